// File: rtl/buffer_pkg.sv
// Shared constants and width helpers for the multi-channel sample buffer.
package buffer_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DROP_CNT_W     = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  // One extra bit so the level can represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int ch_w(input int channels);
    return (channels < 2) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Single-channel FIFO: memory, pointers and fill level; head word is read
// combinationally so the top-level output register can capture it on a pop.
module chan_fifo
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16,
  localparam int PTR_W     = ptr_w(DEPTH),
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      level,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      level_q, level_d;
  logic                  wr_en;
  logic                  rd_en;

  // Ready comes from the registered level only, so a same-cycle pop never frees a slot.
  assign wr_ready  = (level_q != CNT_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;

  always_comb begin
    wr_en    = wr_valid && wr_ready;
    rd_en    = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    level_d  = level_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/multi_channel_buffer.sv
// CHANNELS independent FIFOs drained through one registered output port by a
// round-robin arbiter. Optional overflow counters: BUFFER_DROP_CNT_EN.
module multi_channel_buffer
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 16,
  localparam int PTR_W     = ptr_w(DEPTH),
  localparam int CNT_W     = cnt_w(DEPTH),
  localparam int CH_W      = ch_w(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CH_W-1:0]                out_chan,
  output logic                           out_valid,
  input  logic                           out_read,
  output logic [CHANNELS*CNT_W-1:0]      level,
  output logic [CHANNELS*DROP_CNT_W-1:0] drop_cnt
);

  logic [DATA_WIDTH-1:0] head_data [CHANNELS];
  logic [CHANNELS-1:0]   empty;
  logic [CHANNELS-1:0]   pop;

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]       out_chan_q, out_chan_d;
  logic                  out_valid_q, out_valid_d;
  logic [CH_W-1:0]       rr_q, rr_d;

  logic                  free;
  logic                  grant_valid;
  logic [CH_W-1:0]       grant;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    chan_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .wr_valid (in_valid[c]),
      .wr_ready (in_ready[c]),
      .pop      (pop[c]),
      .head_data(head_data[c]),
      .level    (level[c*CNT_W +: CNT_W]),
      .empty    (empty[c])
    );
  end

  assign free = !out_valid_q || out_read;

  // Search starts one past the last grant so every channel gets its turn.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant       = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(rr_q) + i) % CHANNELS;
      if (!grant_valid && !empty[idx]) begin
        grant_valid = 1'b1;
        grant       = CH_W'(idx);
      end
    end
  end

  always_comb begin
    pop         = '0;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_d        = rr_q;
    if (free) begin
      if (grant_valid) begin
        pop[grant]  = 1'b1;
        out_data_d  = head_data[grant];
        out_chan_d  = grant;
        out_valid_d = 1'b1;
        rr_d        = grant;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_q        <= CH_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_q        <= rr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

`ifdef BUFFER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_q [CHANNELS];
  logic [DROP_CNT_W-1:0] drop_d [CHANNELS];

  // Counts refused write attempts; saturates instead of wrapping.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      drop_d[c] = drop_q[c];
      if (in_valid[c] && !in_ready[c] && (drop_q[c] != '1)) drop_d[c] = drop_q[c] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) drop_q[c] <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int c = 0; c < CHANNELS; c++) drop_cnt[c*DROP_CNT_W +: DROP_CNT_W] = drop_q[c];
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_channel_buffer.sv
// Scoreboard bench for multi_channel_buffer (4 channels x 16 words x 32 bits).
module tb_multi_channel_buffer;

  localparam int DW    = 32;
  localparam int CH    = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int CH_W  = 2;
`ifdef BUFFER_DROP_CNT_EN
  localparam logic [31:0] DROP_EXP = 32'd1;
`else
  localparam logic [31:0] DROP_EXP = 32'd0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [CH*DW-1:0]   in_data;
  logic [CH-1:0]      in_valid;
  logic [CH-1:0]      in_ready;
  logic [DW-1:0]      out_data;
  logic [CH_W-1:0]    out_chan;
  logic               out_valid;
  logic               out_read;
  logic [CH*CNT_W-1:0] level;
  logic [CH*8-1:0]    drop_cnt;

  always #5 clk = ~clk;

  multi_channel_buffer #(
    .DATA_WIDTH(DW),
    .CHANNELS  (CH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_read (out_read),
    .level    (level),
    .drop_cnt (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lvl(input int c);
    return 32'(level[c*CNT_W +: CNT_W]);
  endfunction

  function automatic logic [31:0] drp(input int c);
    return 32'(drop_cnt[c*8 +: 8]);
  endfunction

  // Scoreboard: per-channel expected words, pushed on accept, popped on output handshake.
  logic [DW-1:0] sb [CH][$];
  int pop_cnt [CH];
  int max_l1 = 0;

  initial for (int c = 0; c < CH; c++) pop_cnt[c] = 0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) sb[c].delete();
    end else begin
      for (int c = 0; c < CH; c++)
        if (in_valid[c] && in_ready[c]) sb[c].push_back(in_data[c*DW +: DW]);
      if (int'(lvl(1)) > max_l1) max_l1 = int'(lvl(1));
      if (out_valid && out_read) begin
        if (sb[out_chan].size() == 0) begin
          check_val("sb_nonempty", 32'(sb[out_chan].size() > 0), 32'd1);
        end else begin
          check_val("out_data", out_data, sb[out_chan].pop_front());
          pop_cnt[out_chan]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic done;
    done     = 1'b0;
    out_read = 1'b1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (!out_valid && level == '0) begin
        done = 1'b1;
        break;
      end
    end
    out_read = 1'b0;
    check_val("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    int i, cyc, base;
    logic acc;
    rst      = 1'b0;
    in_valid = '0;
    in_data  = '0;
    out_read = 1'b0;
    repeat (2) tick();

    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", out_data, 32'd0);
    check_val("rst_out_chan", 32'(out_chan), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'hF);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_drop", drop_cnt, 32'd0);

    rst = 1'b1;
    tick();

    // Basic transfer on channel 2
    in_data[2*DW +: DW] = 32'hA5A5_0001;
    in_valid = 4'b0100;
    out_read = 1'b1;
    tick();
    in_valid = '0;
    check_val("basic_level_after_wr", lvl(2), 32'd1);
    check_val("basic_no_bypass", 32'(out_valid), 32'd0);
    tick();
    check_val("basic_out_valid", 32'(out_valid), 32'd1);
    check_val("basic_out_data", out_data, 32'hA5A5_0001);
    check_val("basic_out_chan", 32'(out_chan), 32'd2);
    check_val("basic_level_after_rd", lvl(2), 32'd0);
    tick();
    check_val("basic_empty_after", 32'(out_valid), 32'd0);
    out_read = 1'b0;

    // Full boundary on channel 0: one word sits in the output register, 16 in the FIFO
    for (int k = 0; k < 17; k++) begin
      in_data[0 +: DW] = 32'h1000 + k;
      in_valid = 4'b0001;
      tick();
    end
    check_val("full_in_ready", 32'(in_ready[0]), 32'd0);
    check_val("full_level", lvl(0), 32'd16);
    check_val("full_out_held", 32'(out_valid), 32'd1);
    in_data[0 +: DW] = 32'h1011;
    tick();
    in_valid = '0;
    check_val("full_refused_level", lvl(0), 32'd16);
    check_val("full_drop", drp(0), DROP_EXP);
    out_read = 1'b1;
    check_val("full_ready_during_read", 32'(in_ready[0]), 32'd0);
    tick();
    out_read = 1'b0;
    check_val("full_ready_after_read", 32'(in_ready[0]), 32'd1);
    check_val("full_level_after_read", lvl(0), 32'd15);
    drain();

    // Wrap-around: 40 words through channel 1 with random back-pressure
    base   = pop_cnt[1];
    max_l1 = 0;
    i      = 0;
    cyc    = 0;
    while (i < 40 && cyc < 2000) begin
      in_data[1*DW +: DW] = 32'(i);
      in_valid = 4'b0010;
      out_read = 1'($urandom_range(0, 1));
      acc = in_ready[1];
      tick();
      if (acc) i++;
      cyc++;
    end
    in_valid = '0;
    check_val("wrap_sent", 32'(i), 32'd40);
    drain();
    check_val("wrap_count", 32'(pop_cnt[1] - base), 32'd40);
    check_val("wrap_max_level_ok", 32'(max_l1 <= DEPTH), 32'd1);

    // Round-robin from a fresh reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = 32'hC000_0000 | (c << 8) | j;
      in_valid = 4'hF;
      tick();
    end
    in_valid = '0;
    tick();
    out_read = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check_val("rr_valid", 32'(out_valid), 32'd1);
      check_val("rr_chan", 32'(out_chan), 32'(k % CH));
      tick();
    end
    check_val("rr_done", 32'(out_valid), 32'd0);
    out_read = 1'b0;

    // Simultaneous write and read on channel 3 at level 5
    for (int j = 0; j < 6; j++) begin
      in_data[3*DW +: DW] = 32'h3300 + j;
      in_valid = 4'b1000;
      tick();
    end
    in_valid = '0;
    check_val("simul_level_before", lvl(3), 32'd5);
    in_data[3*DW +: DW] = 32'h3306;
    in_valid = 4'b1000;
    out_read = 1'b1;
    tick();
    in_valid = '0;
    out_read = 1'b0;
    check_val("simul_level_after", lvl(3), 32'd5);
    check_val("simul_out_data", out_data, 32'h3301);
    drain();

    // Reset mid-operation
    for (int j = 0; j < 2; j++) begin
      for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = 32'hEE00 + (c << 4) + j;
      in_valid = 4'hF;
      tick();
    end
    in_valid = '0;
    check_val("mid_partial_fill", 32'(level != '0), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_val("mid_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_level", 32'(level), 32'd0);
    check_val("mid_in_ready", 32'(in_ready), 32'hF);
    check_val("mid_drop", drop_cnt, 32'd0);
    base = pop_cnt[1];
    for (int j = 0; j < 2; j++) begin
      in_data[1*DW +: DW] = 32'h7700 + j;
      in_valid = 4'b0010;
      tick();
    end
    in_valid = '0;
    tick();
    check_val("mid_first_word", out_data, 32'h7700);
    check_val("mid_first_chan", 32'(out_chan), 32'd1);
    drain();
    check_val("mid_count", 32'(pop_cnt[1] - base), 32'd2);

    check_val("sb_all_empty",
              32'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
